// File: rtl/lanes_pkg.sv
// lanes_pkg
// Shared types and constants for the 6-lane SIMD decode/execute slice:
// lane geometry, vector type, ALU opcodes, flag indices, and the ID/EX
// pipeline record.
package lanes_pkg;

    localparam int LANES  = 6;
    localparam int LW     = 8;
    localparam int NREGS  = 16;
    localparam int AW     = $clog2(NREGS);
    localparam int SHW    = 3;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

    typedef logic [LANES-1:0][LW-1:0] vec_t;
    typedef logic [1:0][LANES-1:0]    flags_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MOV = 3'b010,
        OP_MUL = 3'b011,
        OP_SHL = 3'b100,
        OP_SHR = 3'b101,
        OP_AND = 3'b110,
        OP_XOR = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic            regwrite;
        logic            memtoreg;
        logic            memwrite;
        logic            alusrc;
        logic            flagswrite;
        alu_op_e         alu_op;
        logic [AW-1:0]   wa3;
        vec_t            rd1;
        vec_t            rd2;
        logic [SHW-1:0]  rd2i;
        logic [LW-1:0]   ext_imm;
    } idex_t;

endpackage

// File: rtl/regfile_alu_lanes_if.sv
// regfile_alu_lanes_if
// Bundles the decode-stage inputs and execute-stage outputs of the
// regfile_alu_lanes slice.
//   master : drives WE3/A1/A2/A3/WD3 and the D-stage controls,
//            observes RD2I and the E-stage / result outputs
//   slave  : the slice itself
interface regfile_alu_lanes_if;
    import lanes_pkg::*;

    logic                WE3;
    logic [AW-1:0]       A1;
    logic [AW-1:0]       A2;
    logic [AW-1:0]       A3;
    vec_t                WD3;

    logic                RegWriteD;
    logic                MemtoRegD;
    logic                MemWriteD;
    logic                ALUSrcD;
    logic                FlagsWriteD;
    logic [2:0]          ALUControlD;
    logic [AW-1:0]       WA3D;
    logic [LW-1:0]       ExtImmD;

    logic [SHW-1:0]      RD2I;
    logic                RegWriteE;
    logic                MemtoRegE;
    logic                MemWriteE;
    logic                FlagsWriteE;
    logic [AW-1:0]       WA3E;
    vec_t                rd2E;
    vec_t                vector;
    flags_t              ALUFlags;

    modport master (
        output WE3, A1, A2, A3, WD3,
        output RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, FlagsWriteD,
        output ALUControlD, WA3D, ExtImmD,
        input  RD2I, RegWriteE, MemtoRegE, MemWriteE, FlagsWriteE,
        input  WA3E, rd2E, vector, ALUFlags
    );

    modport slave (
        input  WE3, A1, A2, A3, WD3,
        input  RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, FlagsWriteD,
        input  ALUControlD, WA3D, ExtImmD,
        output RD2I, RegWriteE, MemtoRegE, MemWriteE, FlagsWriteE,
        output WA3E, rd2E, vector, ALUFlags
    );

endinterface

// File: rtl/alu_lane.sv
// alu_lane
// One 8-bit SIMD lane: purely combinational, no interaction with other lanes.
//   op_i    : operation
//   a_i     : operand A
//   b_i     : operand B
//   shamt_i : shift amount for SHL/SHR
//   res_o   : result (wraps modulo 256)
//   z_o     : result is zero
//   c_o     : carry / no-borrow / product overflow, 0 for logic ops
module alu_lane
    import lanes_pkg::*;
(
    input  alu_op_e         op_i,
    input  logic [LW-1:0]   a_i,
    input  logic [LW-1:0]   b_i,
    input  logic [SHW-1:0]  shamt_i,
    output logic [LW-1:0]   res_o,
    output logic            z_o,
    output logic            c_o
);

    logic [LW:0]     sum;
    logic [LW:0]     diff;
    logic [2*LW-1:0] prod;

    always_comb begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        diff  = {1'b0, a_i} - {1'b0, b_i};
        prod  = {{LW{1'b0}}, a_i} * {{LW{1'b0}}, b_i};
        res_o = '0;
        c_o   = 1'b0;
        case (op_i)
            OP_ADD: begin
                res_o = sum[LW-1:0];
                c_o   = sum[LW];
            end
            OP_SUB: begin
                res_o = diff[LW-1:0];
                // borrow shows up as the ninth bit; carry means A >= B
                c_o   = ~diff[LW];
            end
            OP_MOV: res_o = b_i;
            OP_MUL: begin
                res_o = prod[LW-1:0];
                c_o   = |prod[2*LW-1:LW];
            end
            OP_SHL: res_o = a_i << shamt_i;
            OP_SHR: res_o = a_i >> shamt_i;
            OP_AND: res_o = a_i & b_i;
            OP_XOR: res_o = a_i ^ b_i;
            default: res_o = '0;
        endcase
        z_o = (res_o == '0);
    end

endmodule

// File: rtl/regfile_alu_lanes.sv
// regfile_alu_lanes
// Decode/execute slice of the 6-lane SIMD pipeline: 16 x (6x8) vector
// register file, ID/EX pipeline register, and a 6-lane ALU with registered
// result and flags. Advances every cycle (no stall/flush).
//   clk   : rising-edge clock
//   reset : synchronous active-high; clears regfile, ID/EX and result regs
//   bus   : regfile_alu_lanes_if.slave (decode inputs, execute outputs)
// Build option: define REGFILE_BYPASS_EN to forward WD3 to a same-cycle
// read of the register being written; otherwise reads see stored contents.
module regfile_alu_lanes
    import lanes_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    regfile_alu_lanes_if.slave bus
);

    vec_t             regs_q [NREGS];
    vec_t             rd1;
    vec_t             rd2;

    idex_t            idex_d;
    idex_t            idex_q;

    vec_t             srcb;
    vec_t             res_w;
    logic [LANES-1:0] z_w;
    logic [LANES-1:0] c_w;

    vec_t             vector_d;
    vec_t             vector_q;
    flags_t           flags_d;
    flags_t           flags_q;

    // Register file (reset wins over a same-cycle write)
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.WE3) begin
            regs_q[bus.A3] <= bus.WD3;
        end
    end

    always_comb begin
        rd1 = regs_q[bus.A1];
        rd2 = regs_q[bus.A2];
`ifdef REGFILE_BYPASS_EN
        // forward only writes that will actually land this edge
        if (bus.WE3 && !reset && (bus.A3 == bus.A1)) rd1 = bus.WD3;
        if (bus.WE3 && !reset && (bus.A3 == bus.A2)) rd2 = bus.WD3;
`endif
    end

    assign bus.RD2I = rd2[0][SHW-1:0];

    // ID/EX register; all-zero is a NOP
    always_comb begin
        idex_d            = '0;
        idex_d.regwrite   = bus.RegWriteD;
        idex_d.memtoreg   = bus.MemtoRegD;
        idex_d.memwrite   = bus.MemWriteD;
        idex_d.alusrc     = bus.ALUSrcD;
        idex_d.flagswrite = bus.FlagsWriteD;
        idex_d.alu_op     = alu_op_e'(bus.ALUControlD);
        idex_d.wa3        = bus.WA3D;
        idex_d.rd1        = rd1;
        idex_d.rd2        = rd2;
        idex_d.rd2i       = rd2[0][SHW-1:0];
        idex_d.ext_imm    = bus.ExtImmD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    // Execute: immediate is broadcast to every lane
    always_comb begin
        srcb = '0;
        for (int i = 0; i < LANES; i++) begin
            srcb[i] = idex_q.alusrc ? idex_q.ext_imm : idex_q.rd2[i];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        alu_lane u_lane (
            .op_i    (idex_q.alu_op),
            .a_i     (idex_q.rd1[g]),
            .b_i     (srcb[g]),
            .shamt_i (idex_q.rd2i),
            .res_o   (res_w[g]),
            .z_o     (z_w[g]),
            .c_o     (c_w[g])
        );
    end

    always_comb begin
        vector_d         = res_w;
        flags_d          = '0;
        flags_d[FLAG_Z]  = z_w;
        flags_d[FLAG_C]  = c_w;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vector_q <= '0;
            flags_q  <= '0;
        end else begin
            vector_q <= vector_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.RegWriteE   = idex_q.regwrite;
    assign bus.MemtoRegE   = idex_q.memtoreg;
    assign bus.MemWriteE   = idex_q.memwrite;
    assign bus.FlagsWriteE = idex_q.flagswrite;
    assign bus.WA3E        = idex_q.wa3;
    assign bus.rd2E        = idex_q.rd2;
    assign bus.vector      = vector_q;
    assign bus.ALUFlags    = flags_q;

endmodule

// File: tb/tb_regfile_alu_lanes.sv
// tb_regfile_alu_lanes
// Directed self-checking bench for regfile_alu_lanes. Expected values are
// hand-computed constants. Define REGFILE_BYPASS_EN to match a bypass build.
module tb_regfile_alu_lanes;
    import lanes_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    regfile_alu_lanes_if bus ();

    regfile_alu_lanes dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [47:0] data);
        bus.WE3 = 1'b1;
        bus.A3  = addr;
        bus.WD3 = data;
        tick();
        bus.WE3 = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [47:0] exp_vec, input logic [11:0] exp_flg);
        bus.ALUControlD = op;
        tick();
        tick();
        chk({tag, ".vector"}, bus.vector, exp_vec);
        chk({tag, ".flags"}, bus.ALUFlags, {36'd0, exp_flg});
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // reset with D controls deliberately non-zero
        reset           = 1'b1;
        bus.WE3         = 1'b0;
        bus.A1          = '0;
        bus.A2          = '0;
        bus.A3          = '0;
        bus.WD3         = '0;
        bus.RegWriteD   = 1'b1;
        bus.MemtoRegD   = 1'b1;
        bus.MemWriteD   = 1'b1;
        bus.ALUSrcD     = 1'b0;
        bus.FlagsWriteD = 1'b1;
        bus.ALUControlD = 3'b000;
        bus.WA3D        = 4'hF;
        bus.ExtImmD     = 8'h00;
        tick();
        tick();
        chk("rst.RegWriteE",   bus.RegWriteE,   0);
        chk("rst.MemtoRegE",   bus.MemtoRegE,   0);
        chk("rst.MemWriteE",   bus.MemWriteE,   0);
        chk("rst.FlagsWriteE", bus.FlagsWriteE, 0);
        chk("rst.WA3E",        bus.WA3E,        0);
        chk("rst.rd2E",        bus.rd2E,        0);
        chk("rst.vector",      bus.vector,      0);
        chk("rst.ALUFlags",    bus.ALUFlags,    0);

        reset           = 1'b0;
        bus.RegWriteD   = 1'b0;
        bus.MemtoRegD   = 1'b0;
        bus.MemWriteD   = 1'b0;
        bus.FlagsWriteD = 1'b0;
        bus.WA3D        = 4'h0;

        for (int i = 0; i < 16; i++) begin
            bus.A2 = 4'(i);
            tick();
            chk($sformatf("rst.reg%0d", i), bus.rd2E, 0);
        end

        // basic lane ops on reg6/reg7
        wr(4'd6, 48'h0F0E0D0C0B0A);
        wr(4'd7, 48'h050403020100);
        bus.A1          = 4'd6;
        bus.A2          = 4'd7;
        bus.ALUSrcD     = 1'b0;
        bus.RegWriteD   = 1'b1;
        bus.FlagsWriteD = 1'b1;
        bus.WA3D        = 4'd3;
        bus.ALUControlD = 3'b000;
        #1;
        chk("rd2i.reg7", bus.RD2I, 0);
        tick();
        chk("ctl.RegWriteE",   bus.RegWriteE,   1);
        chk("ctl.FlagsWriteE", bus.FlagsWriteE, 1);
        chk("ctl.MemWriteE",   bus.MemWriteE,   0);
        chk("ctl.WA3E",        bus.WA3E,        3);
        chk("ctl.rd2E",        bus.rd2E,        48'h050403020100);

        run_op("add", 3'b000, 48'h14121_00E0C0A, 12'h000);
        run_op("sub", 3'b001, 48'h0A0A0A0A0A0A, 12'hFC0);
        run_op("mov", 3'b010, 48'h050403020100, 12'h001);
        run_op("mul", 3'b011, 48'h4B3827180B00, 12'h001);

        // immediate broadcast
        bus.ALUSrcD = 1'b1;
        bus.ExtImmD = 8'hFF;
        run_op("addi", 3'b000, 48'h0E0D0C0B0A09, 12'hFC0);

        // latency: D change at edge N, E fields at N, result at N+1
        bus.ALUControlD = 3'b010;
        bus.WA3D        = 4'd9;
        bus.A2          = 4'd6;
        tick();
        chk("lat.WA3E",       bus.WA3E,   9);
        chk("lat.rd2E",       bus.rd2E,   48'h0F0E0D0C0B0A);
        chk("lat.vector_old", bus.vector, 48'h0E0D0C0B0A09);
        tick();
        chk("lat.vector_new", bus.vector, 48'hFFFFFFFFFFFF);
        chk("lat.flags_new",  bus.ALUFlags, 0);

        // shifts and boundaries
        bus.ALUSrcD = 1'b0;
        wr(4'd8,  {6{8'h81}});
        wr(4'd9,  48'h000000000003);
        wr(4'd10, {6{8'h10}});
        bus.A1 = 4'd8;
        bus.A2 = 4'd9;
        #1;
        chk("rd2i.reg9", bus.RD2I, 3);
        run_op("shl", 3'b100, {6{8'h08}}, 12'h000);
        run_op("shr", 3'b101, {6{8'h10}}, 12'h000);
        bus.A1 = 4'd10;
        bus.A2 = 4'd10;
        run_op("mul_ovf", 3'b011, 48'h0, 12'hFFF);
        run_op("sub_eq",  3'b001, 48'h0, 12'hFFF);
        bus.A2 = 4'd8;
        run_op("sub_brw", 3'b001, {6{8'h8F}}, 12'h000);
        run_op("and",     3'b110, 48'h0, 12'h03F);
        run_op("xor",     3'b111, {6{8'h91}}, 12'h000);

        // same-cycle write/read of reg5
        wr(4'd5, {6{8'h11}});
        bus.WE3 = 1'b1;
        bus.A3  = 4'd5;
        bus.WD3 = {6{8'h22}};
        bus.A2  = 4'd5;
        #1;
        chk("rw.RD2I_same", bus.RD2I, BYP ? 48'd2 : 48'd1);
        tick();
        bus.WE3 = 1'b0;
        chk("rw.rd2E_same", bus.rd2E, BYP ? {6{8'h22}} : {6{8'h11}});
        #1;
        chk("rw.RD2I_next", bus.RD2I, 2);
        tick();
        chk("rw.rd2E_next", bus.rd2E, {6{8'h22}});

        // reset mid-operation together with a write
        reset   = 1'b1;
        bus.WE3 = 1'b1;
        bus.A3  = 4'd5;
        bus.WD3 = {6{8'h33}};
        tick();
        chk("mrst.vector",    bus.vector,    0);
        chk("mrst.ALUFlags",  bus.ALUFlags,  0);
        chk("mrst.RegWriteE", bus.RegWriteE, 0);
        chk("mrst.rd2E",      bus.rd2E,      0);
        reset   = 1'b0;
        bus.WE3 = 1'b0;
        bus.A2  = 4'd5;
        #1;
        chk("mrst.RD2I", bus.RD2I, 0);
        tick();
        chk("mrst.reg5", bus.rd2E, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_alu_lanes.md
Name: regfile_alu_lanes

Overview:
- Decode/execute slice of the 6-lane SIMD pipeline CPU.
- Contains three parts:
  - a 16-entry vector register file, 6 lanes x 8 bit per entry;
  - the ID/EX pipeline register;
  - a 6-lane 8-bit ALU with a registered result.
- Decode-stage controls and register addresses go in. Execute-stage controls, store data, lane results and per-lane flags come out.

Parameters:
- LANES, 6, number of 8-bit lanes per vector register
- LW, 8, lane width in bits
- NREGS, 16, register count (address width is 4)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- WE3  in  1  register-file write enable
- A1, A2, A3  in  4 each  read port 1, read port 2, and write address
- WD3  in  LANESxLW  write data
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, FlagsWriteD  in  1 each  decode controls
- ALUControlD  in  3  ALU operation
- WA3D  in  4  destination register
- ExtImmD  in  8  extended immediate
- RD2I  out  3  scalar taken from read port 2 (decode stage)
- RegWriteE, MemtoRegE, MemWriteE, FlagsWriteE  out  1 each  registered controls
- WA3E  out  4  registered destination
- rd2E  out  LANESxLW  registered store data
- vector  out  LANESxLW  registered lane results
- ALUFlags  out  2xLANES  registered flags: [0] is Z per lane, [1] is C per lane

Behaviour:
- Register file:
  - Write: on posedge, when WE3=1, reg[A3] <= WD3.
  - Read: RD1 = reg[A1] and RD2 = reg[A2], combinational.
  - RD2I = RD2[lane0][2:0].
  - Reset clears all registers to 0.
- ID/EX register:
  - On every posedge it captures all D controls, WA3D, RD1, RD2, RD2I and ExtImmD into the E copies.
  - Reset zeroes every E field, which makes it a NOP (RegWrite and MemWrite both 0).
- ALU:
  - Operands: SrcA = rd1E. SrcB = ALUSrcE ? ExtImmE broadcast to all lanes : rd2E.
  - Each lane computes independently.
  - Operations by ALUControlE:
    - 000 ADD: A+B; C = carry out.
    - 001 SUB: A-B; C = 1 when no borrow (A>=B).
    - 010 MOV: B; C = 0.
    - 011 MUL: low 8 bits of A*B; C = 1 when the upper 8 bits of the product are nonzero.
    - 100 SHL: A << rd2iE; C = 0.
    - 101 SHR: logical A >> rd2iE; C = 0.
    - 110 AND: A & B; C = 0.
    - 111 XOR: A ^ B; C = 0.
  - Z per lane = (result == 0).
  - All arithmetic wraps modulo 256.
  - No lane interacts with another lane (no inter-lane carry).
- Result register: vector and ALUFlags register the ALU output on posedge; reset clears both to 0.
- Latency: inputs sampled at edge N reach the E outputs after edge N; vector and ALUFlags are valid after edge N+1.
- The pipeline has no stall and no flush; it advances every cycle.
- Reset has priority over WE3 in the same cycle, including reset asserted mid-operation.
- Read and write of the same register in one cycle:
  - Without the bypass macro, the read returns the old value.
  - A3 equal to A1 or A2 behaves identically to any other address.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when WE3=1 and A3 matches A1 (or A2), RD1 (or RD2, and therefore RD2I) returns WD3 in the same cycle (write-through).
- Undefined: reads return stored contents only. The new value is visible starting the cycle after the write.

Decomposition:
- Package lanes_pkg holds:
  - constants LANES, LW, NREGS;
  - typedef vec_t (packed [LANES-1:0][LW-1:0]);
  - enum alu_op_e with the 8 opcodes;
  - flag index constants FLAG_Z=0 and FLAG_C=1.
- One natural sub-module is alu_lane: a single 8-bit lane taking op, a, b and shamt and producing res, z and c. Instantiate it LANES times in a generate loop.
- The regfile and the ID/EX register stay inline.

Test Plan:
1. Reset, then read all 16 registers -> zeros. vector=0, ALUFlags=0, every E control 0.
2. Write reg6={0F,0E,0D,0C,0B,0A} and reg7={05,04,03,02,01,00}; set A1=6, A2=7, ALUSrcD=0 -> RD2I=0.
   - ADD -> vector {20,18,16,14,12,10}
   - SUB -> {10,10,10,10,10,10} with C all 1
   - MOV -> {5,4,3,2,1,0} with Z lane0=1
   - MUL -> {75,56,39,24,11,0}
3. ALUSrcD=1, ExtImmD=0xFF, ADD with reg6 -> lanes {0E,0D,0C,0B,0A,09}, C all 1.
4. Latency check: change ALUControlD at edge N -> vector updates exactly at edge N+1 and not earlier. WA3E and rd2E follow one edge after D.
5. SHL with lane0 of reg A2 = 3, A = 0x81 in all lanes -> 0x08 in all lanes. MUL 0x10*0x10 -> 0x00 with Z=1 and C=1.
6. Same-cycle write/read of reg5:
   - REGFILE_BYPASS_EN defined -> new data is read that cycle.
   - Undefined -> old data that cycle, new data the next cycle.
   - Reset asserted together with WE3 -> register stays 0.
